// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
//   rx_fifo_state_t    : capture FSM states used by uart_rx_fifo
//   UART_DATA_LEN      : default byte width
//   UART_RX_FIFO_DEPTH : default receive FIFO depth (power of two, >= 2)
package uart_pkg;

    localparam int UART_DATA_LEN      = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } rx_fifo_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and the
// system-side consumer.
//   rx_data / rx_data_ready / rx_overwritten / rx_parity_error : receiver side
//   rx_data_readed                                            : ack to receiver
//   out_data / out_valid / out_ready                          : FWFT consumer side
//   out_perr : parity tag of out_data (only with UART_RX_FIFO_PERR_TAG_EN)
// Modports: slave = the FIFO block, master = receiver + consumer environment.
interface uart_rx_fifo_if #(
    parameter int DATA_LEN = 8
);
    logic [DATA_LEN-1:0] rx_data;
    logic                rx_data_ready;
    logic                rx_overwritten;
    logic                rx_parity_error;
    logic                rx_data_readed;
    logic [DATA_LEN-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
`ifdef UART_RX_FIFO_PERR_TAG_EN
    logic                out_perr;
`endif

    modport slave (
        input  rx_data,
        input  rx_data_ready,
        input  rx_overwritten,
        input  rx_parity_error,
        output rx_data_readed,
        output out_data,
        output out_valid,
`ifdef UART_RX_FIFO_PERR_TAG_EN
        output out_perr,
`endif
        input  out_ready
    );

    modport master (
        output rx_data,
        output rx_data_ready,
        output rx_overwritten,
        output rx_parity_error,
        input  rx_data_readed,
        input  out_data,
        input  out_valid,
`ifdef UART_RX_FIFO_PERR_TAG_EN
        input  out_perr,
`endif
        output out_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst (sync, active-low)
//   push/wr_data : write request, ignored while full
//   pop/rd_data  : read request, ignored while empty; rd_data is the head,
//                  forced to zero while empty
//   full, empty, level (0..DEPTH)
// Pointers wrap modulo DEPTH; occupancy is kept in its own counter so that
// full and empty are unambiguous without an extra pointer bit.
module uart_sync_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [ADDR_W:0]  level
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (ADDR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    // Legality is judged on the pre-edge level: a full FIFO refuses a
    // write even when a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; contents are only observable while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO stage behind the UART receiver's holding register.
// Captures one byte per rx_data_ready assertion, acknowledges it with a
// one-cycle rx_data_readed pulse, buffers it, and presents the head on a
// first-word-fall-through valid/ready port. Tracks receiver overruns in a
// sticky overflow flag.
//   clk, rst (sync, active-low)
//   bus            : uart_rx_fifo_if.slave (receiver and consumer handshakes)
//   level          : FIFO occupancy, 0..DEPTH
//   overflow       : sticky, set by rx_overwritten
//   clear_overflow : clears overflow; a simultaneous set wins
// Optional build macro UART_RX_FIFO_PERR_TAG_EN: store rx_parity_error with
// each byte and present it on bus.out_perr.
//
// Capture FSM:
//   state    | meaning
//   IDLE     | waiting for rx_data_ready with room in the FIFO; captures
//   ACK      | byte written last edge; rx_data_readed high this cycle
//   WAIT_CLR | waiting for rx_data_ready to drop before the next capture
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_LEN = UART_DATA_LEN,
    parameter  int DEPTH    = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus,
    output logic [ADDR_W:0] level,
    output logic            overflow,
    input  logic            clear_overflow
);

`ifdef UART_RX_FIFO_PERR_TAG_EN
    localparam int WIDTH = DATA_LEN + 1;
`else
    localparam int WIDTH = DATA_LEN;
`endif

    rx_fifo_state_t   state;
    logic             readed_q;
    logic             push;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;

`ifdef UART_RX_FIFO_PERR_TAG_EN
    assign wr_data      = {bus.rx_parity_error, bus.rx_data};
    assign bus.out_data = rd_data[DATA_LEN-1:0];
    assign bus.out_perr = rd_data[DATA_LEN];
`else
    logic unused_perr;
    assign unused_perr  = bus.rx_parity_error;
    assign wr_data      = bus.rx_data;
    assign bus.out_data = rd_data;
`endif

    assign push               = (state == IDLE) && bus.rx_data_ready && !full;
    assign bus.out_valid      = !empty;
    assign bus.rx_data_readed = readed_q;

    uart_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_data),
        .pop     (bus.out_ready),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            readed_q <= 1'b0;
        end else begin
            readed_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (push) begin
                        state    <= ACK;
                        readed_q <= 1'b1;
                    end
                end
                ACK: begin
                    state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // Holding here until ready drops keeps a still-asserted
                    // ready from being captured a second time.
                    if (!bus.rx_data_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (bus.rx_overwritten) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DL    = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_overflow;
    logic [4:0] level;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FIFO contents, whether a new capture is permitted,
    // whether this cycle must show the acknowledge, and the sticky flag.
    logic [7:0] mq[$];
    bit         m_armed;
    bit         m_ack;
    bit         m_ovf;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_LEN(DL)) bus_if ();

    uart_rx_fifo #(
        .DATA_LEN (DL),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    // Advance one clock: update the model from the pre-edge inputs, then
    // sample point is 1 time unit after the edge.
    task automatic cyc();
        bit push;
        bit pop;
        if (!rst) begin
            mq.delete();
            m_armed = 1'b1;
            m_ack   = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && bus_if.out_ready;
            push = m_armed && bus_if.rx_data_ready && (mq.size() < DEPTH);
            if (bus_if.rx_overwritten) m_ovf = 1'b1;
            else if (clear_overflow)   m_ovf = 1'b0;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(bus_if.rx_data);
            // One capture per ready assertion: re-arm only once ready has
            // been seen low after the acknowledge cycle.
            if (push)                                  m_armed = 1'b0;
            else if (!m_ack && !bus_if.rx_data_ready)  m_armed = 1'b1;
            m_ack = push;
        end
        @(posedge clk);
        #1;
    endtask

    // Receiver behaviour: hold the byte until acknowledged, then drop ready.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        bus_if.rx_data       = b;
        bus_if.rx_data_ready = 1'b1;
        for (int k = 0; k < 64 && !got; k++) begin
            cyc();
            if (bus_if.rx_data_readed === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_ack byte=%02h got=no_ack exp=ack", b);
        end
        bus_if.rx_data_ready = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_cmp++;
        if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus_if.out_valid); end
        n_cmp++;
        if (bus_if.rx_data_readed !== 1'b0) begin n_fail++; $display("FAIL reset_readed got=%b exp=0", bus_if.rx_data_readed); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++;
        if (bus_if.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%02h exp=00", bus_if.out_data); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single_byte();
        logic [3:0] exp_ack;
        exp_ack = 4'b0001;
        bus_if.rx_data       = 8'hA5;
        bus_if.rx_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (bus_if.rx_data_readed !== exp_ack[i]) begin
                n_fail++;
                $display("FAIL single_readed cyc=%0d got=%b exp=%b", i, bus_if.rx_data_readed, exp_ack[i]);
            end
            n_cmp++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'hA5) begin
                n_fail++;
                $display("FAIL single_out cyc=%0d got=%b/%02h exp=1/a5", i, bus_if.out_valid, bus_if.out_data);
            end
        end
        bus_if.rx_data_ready = 1'b0;
        cyc();
        n_cmp++;
        if (level !== 5'd1) begin n_fail++; $display("FAIL single_level got=%0d exp=1", level); end
        bus_if.out_ready = 1'b1;
        cyc();
        bus_if.out_ready = 1'b0;
        n_cmp++;
        if (bus_if.out_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop got=%b/%0d exp=0/0", bus_if.out_valid, level);
        end
    endtask

    task automatic test_burst_full();
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        n_cmp++;
        if (level !== 5'd16) begin n_fail++; $display("FAIL full_level got=%0d exp=16", level); end
        bus_if.rx_data       = 8'h10;
        bus_if.rx_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (bus_if.rx_data_readed !== 1'b0 || level !== 5'd16) begin
                n_fail++;
                $display("FAIL full_backpressure cyc=%0d got=%b/%0d exp=0/16", i, bus_if.rx_data_readed, level);
            end
        end
        bus_if.out_ready = 1'b1;
        cyc();
        bus_if.out_ready = 1'b0;
        n_cmp++;
        if (level !== 5'd15 || bus_if.out_data !== 8'h01 || bus_if.rx_data_readed !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop got=%0d/%02h/%b exp=15/01/0", level, bus_if.out_data, bus_if.rx_data_readed);
        end
        cyc();
        n_cmp++;
        if (bus_if.rx_data_readed !== 1'b1 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL full_refill got=%b/%0d exp=1/16", bus_if.rx_data_readed, level);
        end
        bus_if.rx_data_ready = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_drain_order();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL drain_prev i=%0d got=%b/%02h exp=1/%02h", i, bus_if.out_valid, bus_if.out_data, 8'(i + 1));
            end
            cyc();
        end
        for (int r = 0; r < 2; r++) begin
            bus_if.out_ready = 1'b0;
            for (int i = 0; i < 16; i++) send_byte(8'(i));
            bus_if.out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'(i)) begin
                    n_fail++;
                    $display("FAIL drain_order r=%0d i=%0d got=%b/%02h exp=1/%02h", r, i, bus_if.out_valid, bus_if.out_data, 8'(i));
                end
                cyc();
            end
            n_cmp++;
            if (bus_if.out_valid !== 1'b0 || level !== 5'd0) begin
                n_fail++;
                $display("FAIL drain_empty r=%0d got=%b/%0d exp=0/0", r, bus_if.out_valid, level);
            end
        end
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) send_byte(b[i]);
        n_cmp++;
        if (level !== 5'd3) begin n_fail++; $display("FAIL simul_pre_level got=%0d exp=3", level); end
        bus_if.rx_data       = b[3];
        bus_if.rx_data_ready = 1'b1;
        bus_if.out_ready     = 1'b1;
        cyc();
        bus_if.out_ready = 1'b0;
        n_cmp++;
        if (level !== 5'd3 || bus_if.out_data !== b[1] || bus_if.rx_data_readed !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_level got=%0d/%02h/%b exp=3/%02h/1", level, bus_if.out_data, bus_if.rx_data_readed, b[1]);
        end
        bus_if.rx_data_ready = 1'b0;
        cyc();
        cyc();
        bus_if.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (bus_if.out_data !== b[i]) begin
                n_fail++;
                $display("FAIL simul_order i=%0d got=%02h exp=%02h", i, bus_if.out_data, b[i]);
            end
            cyc();
        end
        bus_if.out_ready = 1'b0;
        n_cmp++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL simul_empty got=%0d exp=0", level); end
    endtask

    task automatic test_overflow();
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_idle got=%b exp=0", overflow); end
        bus_if.rx_overwritten = 1'b1;
        cyc();
        bus_if.rx_overwritten = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        bus_if.rx_overwritten = 1'b1;
        clear_overflow        = 1'b1;
        cyc();
        bus_if.rx_overwritten = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        cyc();
        clear_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b5;
        b5 = 8'($urandom);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        bus_if.rx_data       = b5;
        bus_if.rx_data_ready = 1'b1;
        cyc();
        n_cmp++;
        if (bus_if.rx_data_readed !== 1'b1 || level !== 5'd5) begin
            n_fail++;
            $display("FAIL rstmid_pre got=%b/%0d exp=1/5", bus_if.rx_data_readed, level);
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        n_cmp++;
        if (level !== 5'd0 || bus_if.out_valid !== 1'b0 || bus_if.rx_data_readed !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear got=%0d/%b/%b exp=0/0/0", level, bus_if.out_valid, bus_if.rx_data_readed);
        end
        cyc();
        n_cmp++;
        if (bus_if.rx_data_readed !== 1'b1 || level !== 5'd1 || bus_if.out_data !== b5) begin
            n_fail++;
            $display("FAIL rstmid_recapture got=%b/%0d/%02h exp=1/1/%02h", bus_if.rx_data_readed, level, bus_if.out_data, b5);
        end
        bus_if.rx_data_ready = 1'b0;
        cyc();
        cyc();
        bus_if.out_ready = 1'b1;
        cyc();
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int low_cnt;
        low_cnt = 0;
        for (int t = 0; t < 800; t++) begin
            bus_if.out_ready      = ($urandom_range(0, 2) == 0);
            bus_if.rx_overwritten = ($urandom_range(0, 19) == 0);
            clear_overflow        = ($urandom_range(0, 7) == 0);
            if (bus_if.rx_data_ready && bus_if.rx_data_readed) begin
                bus_if.rx_data_ready = 1'b0;
                low_cnt = 1;
            end else if (!bus_if.rx_data_ready) begin
                if (low_cnt > 0) low_cnt--;
                else if ($urandom_range(0, 1) == 0) begin
                    bus_if.rx_data_ready = 1'b1;
                    bus_if.rx_data       = 8'($urandom);
                end
            end
            cyc();
            n_cmp++;
            if (level !== 5'(mq.size())) begin
                n_fail++;
                $display("FAIL rand_level t=%0d got=%0d exp=%0d", t, level, mq.size());
            end
            n_cmp++;
            if (bus_if.out_valid !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_valid t=%0d got=%b exp=%b", t, bus_if.out_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if (bus_if.out_data !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_data t=%0d got=%02h exp=%02h", t, bus_if.out_data, mq[0]);
                end
            end
            n_cmp++;
            if (bus_if.rx_data_readed !== m_ack) begin
                n_fail++;
                $display("FAIL rand_readed t=%0d got=%b exp=%b", t, bus_if.rx_data_readed, m_ack);
            end
            n_cmp++;
            if (overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_overflow t=%0d got=%b exp=%b", t, overflow, m_ovf);
            end
        end
        bus_if.rx_data_ready  = 1'b0;
        bus_if.rx_overwritten = 1'b0;
        clear_overflow        = 1'b1;
        bus_if.out_ready      = 1'b1;
        repeat (20) cyc();
        clear_overflow   = 1'b0;
        bus_if.out_ready = 1'b0;
        n_cmp++;
        if (level !== 5'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_final got=%0d/%b exp=0/0", level, overflow);
        end
    endtask

    initial begin
        rst                    = 1'b0;
        clear_overflow         = 1'b0;
        bus_if.rx_data         = '0;
        bus_if.rx_data_ready   = 1'b0;
        bus_if.rx_overwritten  = 1'b0;
        bus_if.rx_parity_error = 1'b0;
        bus_if.out_ready       = 1'b0;
        m_armed                = 1'b1;
        m_ack                  = 1'b0;
        m_ovf                  = 1'b0;
        #1;
        test_reset();
        test_single_byte();
        test_burst_full();
        test_drain_order();
        test_simul_push_pop();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
